// File: rtl/mem_multicycle_resp_if.sv
// Data-memory request bus between the Memory stage (master/initiator)
// and the multi-cycle memory responder (slave).
interface mem_multicycle_resp_if;
    logic        enable;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        stall;
    logic        done;
    logic        err;

    modport master (
        output enable, wr, addr, data_in,
        input  data_out, stall, done, err
    );

    modport slave (
        input  enable, wr, addr, data_in,
        output data_out, stall, done, err
    );
endinterface

// File: rtl/mem_multicycle_resp.sv
// Multi-cycle data-memory responder. Accepts one request at a time, holds
// stall high for LATENCY cycles, then performs the access and pulses done.
// Storage is a 16-bit word array indexed by addr[DEPTH_LOG2:1]; it is not
// cleared by reset.
// Optional build macro MEM_ALIGN_CHECK_EN: odd byte addresses complete
// without touching storage or data_out and raise err in the done cycle.
// Without it, addr[0] is ignored and err stays 0.
module mem_multicycle_resp #(
    parameter int LATENCY    = 4,   // 1..15
    parameter int DEPTH_LOG2 = 10   // 1..15
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_multicycle_resp_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

`ifdef MEM_ALIGN_CHECK_EN
    localparam logic ALIGN_CHK = 1'b1;
`else
    localparam logic ALIGN_CHK = 1'b0;
`endif

    // Reduction parity; used here only to fold the whole address into a sink.
    function automatic logic parity16(input logic [15:0] v);
        return ^v;
    endfunction

    logic [15:0] mem [0:(2**DEPTH_LOG2)-1];

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    wr_q, wr_d;
    logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
    logic [15:0]             wdata_q, wdata_d;
    logic                    misal_q, misal_d;
    logic                    stall_q, stall_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic [15:0]             data_out_q, data_out_d;
    logic                    mem_we_s;
    logic                    unused_addr_s;

    // Address bits above the word index (and addr[0] when unchecked) are
    // deliberately dropped; this sink keeps them visibly accounted for.
    assign unused_addr_s = parity16(bus.addr);

    // Next-state, request latching and output computation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_d       = wr_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        misal_d    = misal_q;
        stall_d    = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        data_out_d = data_out_q;
        mem_we_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.enable) begin
                    wr_d    = bus.wr;
                    idx_d   = bus.addr[DEPTH_LOG2:1];
                    wdata_d = bus.data_in;
                    misal_d = ALIGN_CHK & bus.addr[0];
                    cnt_d   = LAT_M1;
                    stall_d = 1'b1;
                    state_d = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d   = cnt_q - 4'd1;
                    stall_d = 1'b1;
                end else begin
                    // Access happens on the edge that leaves BUSY.
                    if (!misal_q) begin
                        if (wr_q) begin
                            mem_we_s = 1'b1;
                        end else begin
                            data_out_d = mem[idx_q];
                        end
                    end else begin
                        mem_we_s = 1'b0;
                    end
                    err_d   = misal_q;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                // enable is ignored here so a still-held request is not re-taken.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            wr_q       <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= 16'h0000;
            misal_q    <= 1'b0;
            stall_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            data_out_q <= 16'h0000;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            misal_q    <= misal_d;
            stall_q    <= stall_d;
            done_q     <= done_d;
            err_q      <= err_d;
            data_out_q <= data_out_d;
        end
    end

    // Storage write port; reset blocks the commit but never clears contents.
    always_ff @(posedge clk) begin
        if (!rst && mem_we_s) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.stall    = stall_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_mem_multicycle_resp.sv
// Directed self-checking bench for mem_multicycle_resp. Two instances:
// LATENCY=4 (sel 0) and LATENCY=1 (sel 1). Read expectations come from a
// bench-side memory model and are queued when the request is driven.
module tb_mem_multicycle_resp;

`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_multicycle_resp_if bus4 ();
    mem_multicycle_resp_if bus1 ();

    mem_multicycle_resp #(.LATENCY(4), .DEPTH_LOG2(10)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    mem_multicycle_resp #(.LATENCY(1), .DEPTH_LOG2(10)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] model4 [int];
    logic [15:0] model1 [int];
    logic [15:0] exp_q [$];
    logic [15:0] last_out [2];

    bit          sel_r = 1'b0;
    logic        s_stall, s_done, s_err;
    logic [15:0] s_dout;

    always_comb begin
        if (sel_r) begin
            s_stall = bus1.stall; s_done = bus1.done; s_err = bus1.err; s_dout = bus1.data_out;
        end else begin
            s_stall = bus4.stall; s_done = bus4.done; s_err = bus4.err; s_dout = bus4.data_out;
        end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input bit en, input bit w, input logic [15:0] a, input logic [15:0] d);
        if (sel) begin
            bus1.enable = en; bus1.wr = w; bus1.addr = a; bus1.data_in = d;
        end else begin
            bus4.enable = en; bus4.wr = w; bus4.addr = a; bus4.data_in = d;
        end
    endtask

    // One complete request; called at a negedge, returns at a negedge.
    task automatic req(input bit sel, input bit w, input logic [15:0] a, input logic [15:0] d,
                       input int lat, input bit hold, input string tag);
        int   n;
        int   key;
        bit   unal;
        logic [15:0] e;
        sel_r = sel;
        key   = int'(a[10:1]);
        unal  = ALIGN && a[0];
        if (!w && !unal) begin
            exp_q.push_back(sel ? model1[key] : model4[key]);
        end else if (w && !unal) begin
            if (sel) model1[key] = d; else model4[key] = d;
        end
        drive(sel, 1'b1, w, a, d);
        @(posedge clk);
        @(negedge clk);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (s_done) break;
            if (s_stall) n++;
            @(negedge clk);
        end
        check({tag, " done_seen"}, 16'(s_done), 16'd1);
        check({tag, " stall_cycles"}, 16'(n), 16'(lat));
        check({tag, " stall_in_done"}, 16'(s_stall), 16'd0);
        check({tag, " err"}, 16'(s_err), 16'(unal));
        if (!w && !unal && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, " rdata"}, s_dout, e);
            last_out[sel] = e;
        end else begin
            check({tag, " dout_kept"}, s_dout, last_out[sel]);
        end
        if (!hold) drive(sel, 1'b0, 1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        check({tag, " done_cleared"}, 16'(s_done), 16'd0);
        check({tag, " idle_stall"}, 16'(s_stall), 16'd0);
        check({tag, " err_cleared"}, 16'(s_err), 16'd0);
        check({tag, " dout_hold"}, s_dout, last_out[sel]);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        last_out[0] = 16'h0000;
        last_out[1] = 16'h0000;
        repeat (2) @(negedge clk);
        check("rst stall4", 16'(bus4.stall), 16'd0);
        check("rst done4", 16'(bus4.done), 16'd0);
        check("rst err4", 16'(bus4.err), 16'd0);
        check("rst dout4", bus4.data_out, 16'h0000);
        check("rst stall1", 16'(bus1.stall), 16'd0);
        check("rst dout1", bus1.data_out, 16'h0000);
        rst = 1'b0;
        @(negedge clk);

        // Basic write then read.
        req(1'b0, 1'b1, 16'h0010, 16'hBEEF, 4, 1'b0, "wr10");
        req(1'b0, 1'b0, 16'h0010, 16'h0000, 4, 1'b0, "rd10");

        // Back-to-back: enable dropped in done cycle, next request one cycle later.
        req(1'b0, 1'b1, 16'h0020, 16'h1234, 4, 1'b0, "wr20");
        req(1'b0, 1'b0, 16'h0020, 16'h0000, 4, 1'b0, "rd20");

        // Held enable through done: not re-accepted in done, taken the cycle after.
        req(1'b0, 1'b1, 16'h0050, 16'h2222, 4, 1'b1, "wr50_held");
        req(1'b0, 1'b1, 16'h0050, 16'h2222, 4, 1'b0, "wr50_again");
        req(1'b0, 1'b0, 16'h0050, 16'h0000, 4, 1'b0, "rd50");

        // Reset on the 2nd busy cycle aborts the write.
        req(1'b0, 1'b1, 16'h0030, 16'hAAAA, 4, 1'b0, "wr30");
        sel_r = 1'b0;
        drive(1'b0, 1'b1, 1'b1, 16'h0030, 16'h5555);
        @(posedge clk);
        @(negedge clk);
        check("abort busy1", 16'(s_stall), 16'd1);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        last_out[0] = 16'h0000;
        check("abort stall", 16'(s_stall), 16'd0);
        check("abort done", 16'(s_done), 16'd0);
        check("abort dout", s_dout, 16'h0000);
        repeat (5) @(negedge clk);
        check("abort no_late_done", 16'(s_done), 16'd0);
        req(1'b0, 1'b0, 16'h0030, 16'h0000, 4, 1'b0, "rd30_after_abort");

        // rst and enable together: nothing accepted.
        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 16'h0030, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        check("rst_en stall", 16'(s_stall), 16'd0);
        @(negedge clk);
        check("rst_en stall_next", 16'(s_stall), 16'd0);
        last_out[0] = 16'h0000;

        // Address wrap: 0x0802 aliases 0x0002.
        req(1'b0, 1'b1, 16'h0802, 16'h7777, 4, 1'b0, "wr802");
        req(1'b0, 1'b0, 16'h0002, 16'h0000, 4, 1'b0, "rd002");

        // Odd address handling (err only with the alignment check built in).
        req(1'b0, 1'b1, 16'h0040, 16'h1111, 4, 1'b0, "wr40");
        req(1'b0, 1'b1, 16'h0041, 16'h9999, 4, 1'b0, "wr41");
        req(1'b0, 1'b0, 16'h0040, 16'h0000, 4, 1'b0, "rd40");

        // LATENCY = 1 instance.
        req(1'b1, 1'b1, 16'h0000, 16'h00FF, 1, 1'b0, "l1_wr0");
        req(1'b1, 1'b0, 16'h0000, 16'h0000, 1, 1'b0, "l1_rd0");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
